// File: rtl/dsi_tx_line_reader.sv
// Reads one video line at a time from a show-ahead FIFO and sends it as a DSI long packet (header, then payload words).
// Define DSI_TX_LINE_READER_CRC_EN to compute the payload checksum; otherwise crc_data is 16'h0000.
module dsi_tx_line_reader #(
    parameter int unsigned LINE_BYTES = 640,
    parameter logic [5:0]  DATA_TYPE  = 6'h3E,
    parameter logic [1:0]  VC         = 2'd0,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] fifo_data,
    input  logic        fifo_not_empty,
    input  logic        fifo_line_ready,
    output logic        fifo_read_ack,
    output logic [23:0] hdr_data,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [31:0] pld_data,
    output logic [3:0]  pld_strb,
    output logic        pld_last,
    output logic        pld_valid,
    input  logic        pld_ready,
    output logic [15:0] crc_data,
    output logic        crc_valid,
    output logic        busy,
    output logic        underflow_err,
    input  logic        err_clear
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned REM   = LINE_BYTES % 4;
    localparam logic [CNT_W-1:0] WC    = CNT_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0] WORDS = CNT_W'((LINE_BYTES / 4) + ((REM != 0) ? 1 : 0));
    localparam logic [3:0]       LAST_STRB = (REM == 0) ? 4'hF : 4'((1 << REM) - 1);
    localparam logic [23:0]      HDR_WORD  = {WC, VC, DATA_TYPE};
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HDR, PLD, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             in_pld;

    // Show-ahead FIFO: the head word is presented and popped in the same cycle.
    assign in_pld        = (state == PLD);
    assign pld_valid     = in_pld & fifo_not_empty;
    assign pld_data      = in_pld ? fifo_data : 32'h0;
    assign fifo_read_ack = pld_valid & pld_ready;

    // Line sequencer; pld_last/pld_strb are precomputed for the word about to be offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            hdr_valid <= 1'b0;
            hdr_data  <= '0;
            pld_last  <= 1'b0;
            pld_strb  <= '0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && fifo_line_ready) begin
                        state     <= HDR;
                        hdr_valid <= 1'b1;
                        hdr_data  <= HDR_WORD;
                        busy      <= 1'b1;
                    end
                end
                HDR: begin
                    if (hdr_ready) begin
                        state     <= PLD;
                        hdr_valid <= 1'b0;
                        word_cnt  <= WORDS - CNT_W'(1);
                        pld_last  <= (WORDS == CNT_W'(1));
                        pld_strb  <= (WORDS == CNT_W'(1)) ? LAST_STRB : 4'hF;
                    end
                end
                PLD: begin
                    if (fifo_read_ack) begin
                        if (pld_last) begin
                            state     <= GAP;
                            gap_cnt   <= GAP_LAST;
                            pld_last  <= 1'b0;
                            pld_strb  <= '0;
                            crc_valid <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt - CNT_W'(1);
                            pld_last <= (word_cnt == CNT_W'(1));
                            pld_strb <= (word_cnt == CNT_W'(1)) ? LAST_STRB : 4'hF;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky underflow: sink ready but FIFO starved mid-line; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (err_clear) begin
            underflow_err <= 1'b0;
        end else if (in_pld && pld_ready && !fifo_not_empty) begin
            underflow_err <= 1'b1;
        end
    end

`ifdef DSI_TX_LINE_READER_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_next;

    // Reflected CRC-16 (0x8408) over the enabled bytes, byte0 first.
    function automatic logic [15:0] crc_word(input logic [15:0] crc_in,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                c = c ^ {8'h00, data[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    assign crc_next = crc_word(crc_q, fifo_data, pld_strb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= 16'hFFFF;
            crc_data <= 16'h0000;
        end else if (state == HDR && hdr_ready) begin
            crc_q <= 16'hFFFF;
        end else if (fifo_read_ack) begin
            crc_q <= crc_next;
            if (pld_last) begin
                crc_data <= crc_next;
            end
        end
    end
`else
    assign crc_data = 16'h0000;
`endif

endmodule

// File: tb/tb_dsi_tx_line_reader.sv
// Randomized bench for dsi_tx_line_reader: three instances (640, 6 and 9 byte lines) checked
// every cycle against a line-level reference model, plus directed literal checks.
module tb_dsi_tx_line_reader;
    localparam int unsigned GAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, hdr_ready, pld_ready, stall, err_clear, lr_en;
    int errors = 0;
    int checks = 0;

    task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL [%0d] %s: got %0h expected %0h at %0t", g, name, act, exp, $time);
        end
    endtask

    // Bit-serial reflected CRC-16, init FFFF, no final xor.
    function automatic logic [15:0] crc_model(input logic [7:0] data[$]);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        foreach (data[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ data[i][k];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int unsigned LB    = (g == 0) ? 640 : (g == 1) ? 6 : 9;
        localparam int unsigned WORDS = (LB + 3) / 4;
        localparam int unsigned REM   = LB % 4;
        localparam logic [23:0] HDR   = {16'(LB), 2'd0, 6'h3E};

        logic [31:0] f_data;
        logic        f_ne, f_lr, ack;
        logic [23:0] hdr_data;
        logic        hdr_valid;
        logic [31:0] pld_data;
        logic [3:0]  pld_strb;
        logic        pld_last, pld_valid;
        logic [15:0] crc_data;
        logic        crc_valid, busy, underflow_err;

        logic [31:0] q[$];
        logic [7:0]  bytes[$];
        int pushes = 0;
        bit pop = 1'b0;
        int phase = 0, idx = 0, gapn = 0, lines_done = 0;
        int ack_cnt = 0, last_ack_cnt = 0, pld_cyc = 0, last_pld_cyc = 0;
        bit uerr = 1'b0, first_crc_seen = 1'b0;
        logic [15:0] crc_exp = 16'h0, first_crc = 16'h0;
        logic [3:0]  last_strb_seen = 4'h0;
        logic        exp_pv, is_last;
        logic [3:0]  exp_strb;
        int nb;

        dsi_tx_line_reader #(
            .LINE_BYTES(LB), .DATA_TYPE(6'h3E), .VC(2'd0), .GAP_CYCLES(GAP)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .enable(enable),
            .fifo_data(f_data), .fifo_not_empty(f_ne), .fifo_line_ready(f_lr),
            .fifo_read_ack(ack),
            .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
            .pld_data(pld_data), .pld_strb(pld_strb), .pld_last(pld_last),
            .pld_valid(pld_valid), .pld_ready(pld_ready),
            .crc_data(crc_data), .crc_valid(crc_valid),
            .busy(busy), .underflow_err(underflow_err), .err_clear(err_clear)
        );

        function automatic logic [31:0] gen_word(input int n);
            logic [31:0] r;
            r = $urandom;
            if (LB == 9 && n == 0) return 32'h34333231;
            if (LB == 9 && n == 1) return 32'h38373635;
            if (LB == 9 && n == 2) return {r[23:0], 8'h39};
            return r;
        endfunction

        // FIFO model: pops on the DUT's ack, keeps two lines buffered, flushed by reset.
        initial begin
            f_data = '0; f_ne = 1'b0; f_lr = 1'b0;
            forever begin
                @(posedge clk); #2;
                if (!rst_n) begin
                    q.delete();
                end else begin
                    if (pop && q.size() > 0) void'(q.pop_front());
                    while (q.size() < 2 * WORDS) begin
                        q.push_back(gen_word(pushes));
                        pushes++;
                    end
                end
                pop = 1'b0;
                if (q.size() > 0) f_data = q[0];
                else f_data = '0;
                f_ne = (q.size() > 0) && !stall;
                f_lr = (q.size() >= WORDS) && lr_en;
            end
        end

        // Line-level reference: phase 0 idle, 1 header, 2 payload word idx, 3 gap cycle gapn.
        always @(negedge clk) begin
            if (!rst_n) begin
                chk(g, "rst_hdr_valid", hdr_valid, 0);
                chk(g, "rst_pld_valid", pld_valid, 0);
                chk(g, "rst_ack", ack, 0);
                chk(g, "rst_busy", busy, 0);
                chk(g, "rst_crc_valid", crc_valid, 0);
                chk(g, "rst_uerr", underflow_err, 0);
                chk(g, "rst_strb", pld_strb, 0);
                phase = 0; idx = 0; gapn = 0; uerr = 1'b0; pop = 1'b0; ack_cnt = 0; pld_cyc = 0;
            end else begin
                exp_pv   = (phase == 2) && f_ne;
                is_last  = (phase == 2) && (idx == WORDS - 1);
                exp_strb = (phase != 2) ? 4'h0 : (is_last && REM != 0) ? 4'((1 << REM) - 1) : 4'hF;
                chk(g, "hdr_valid", hdr_valid, (phase == 1));
                if (phase == 1) chk(g, "hdr_data", hdr_data, HDR);
                chk(g, "pld_valid", pld_valid, exp_pv);
                if (exp_pv) chk(g, "pld_data", pld_data, f_data);
                chk(g, "pld_last", pld_last, is_last);
                chk(g, "pld_strb", pld_strb, exp_strb);
                chk(g, "fifo_read_ack", ack, exp_pv && pld_ready);
                chk(g, "busy", busy, (phase != 0));
                chk(g, "crc_valid", crc_valid, (phase == 3 && gapn == 0));
                if (phase == 3 && gapn == 0) begin
                    chk(g, "crc_data", crc_data, crc_exp);
                    chk(g, "acks_per_line", ack_cnt, WORDS);
                    if (!first_crc_seen) begin
                        first_crc = crc_data;
                        first_crc_seen = 1'b1;
                    end
                end
                chk(g, "underflow_err", underflow_err, uerr);
                pop = ack;
                if (ack) begin
                    ack_cnt++;
                    if (pld_last) last_strb_seen = pld_strb;
                end
                if (err_clear) uerr = 1'b0;
                else if (phase == 2 && pld_ready && !f_ne) uerr = 1'b1;
                case (phase)
                    0: if (enable && f_lr) phase = 1;
                    1: if (hdr_ready) begin
                        phase = 2; idx = 0; bytes.delete(); ack_cnt = 0; pld_cyc = 0;
                    end
                    2: begin
                        pld_cyc++;
                        if (exp_pv && pld_ready) begin
                            nb = (is_last && REM != 0) ? REM : 4;
                            for (int b = 0; b < nb; b++) bytes.push_back(f_data[8*b +: 8]);
                            if (is_last) begin
                                phase = 3; gapn = 0; last_pld_cyc = pld_cyc;
`ifdef DSI_TX_LINE_READER_CRC_EN
                                crc_exp = crc_model(bytes);
`else
                                crc_exp = 16'h0000;
`endif
                            end else begin
                                idx++;
                            end
                        end
                    end
                    default: begin
                        if (gapn == GAP - 1) begin
                            phase = 0; lines_done++; last_ack_cnt = ack_cnt;
                        end else begin
                            gapn++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_line0(input int target, input int budget, input string what);
        int n;
        n = 0;
        while (blk[0].lines_done < target && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (blk[0].lines_done < target) begin
            errors++;
            $display("FAIL timeout %s: lines_done %0d expected %0d", what, blk[0].lines_done, target);
        end
    endtask

    task automatic wait_hdr0(input int budget, input string what);
        int n;
        n = 0;
        while (!blk[0].hdr_valid && n < budget) begin
            cyc(1);
            n++;
        end
        chk(0, what, blk[0].hdr_data, 24'h02803E);
    endtask

    initial begin
        int start, n;
        rst_n = 1'b0; enable = 1'b0; hdr_ready = 1'b1; pld_ready = 1'b1;
        stall = 1'b0; err_clear = 1'b0; lr_en = 1'b1;
        cyc(3);
        rst_n = 1'b1;

        // Full line at full throughput; all three instances start together.
        enable = 1'b1;
        wait_hdr0(50, "hdr_literal_640");
        chk(1, "hdr_literal_6", blk[1].hdr_data, 24'h00063E);
        chk(2, "hdr_literal_9", blk[2].hdr_data, 24'h00093E);
        enable = 1'b0;
        wait_line0(1, 400, "full_line");
        chk(0, "pld_cycles_full", blk[0].last_pld_cyc, 160);
        chk(0, "acks_full", blk[0].last_ack_cnt, 160);
        chk(1, "strb_last_6", blk[1].last_strb_seen, 4'h3);
        chk(2, "strb_last_9", blk[2].last_strb_seen, 4'h1);
        chk(2, "crc_seen", blk[2].first_crc_seen, 1);
`ifdef DSI_TX_LINE_READER_CRC_EN
        chk(2, "crc_123456789", blk[2].first_crc, 16'h6F91);
`else
        chk(2, "crc_disabled", blk[2].first_crc, 16'h0000);
`endif
        cyc(2);
        chk(0, "idle_after_gap", blk[0].busy, 0);

        // Backpressure: pld_ready alternates, line takes twice as long.
        start = blk[0].lines_done;
        enable = 1'b1;
        n = 0;
        while (!blk[0].busy && n < 50) begin cyc(1); n++; end
        enable = 1'b0;
        n = 0;
        while (blk[0].lines_done < start + 1 && n < 1000) begin
            pld_ready = ~pld_ready;
            cyc(1);
            n++;
        end
        pld_ready = 1'b1;
        wait_line0(start + 1, 10, "backpressure_line");
        checks++;
        if (blk[0].last_pld_cyc != 319 && blk[0].last_pld_cyc != 320) begin
            errors++;
            $display("FAIL bp_cycles: got %0d expected 319..320", blk[0].last_pld_cyc);
        end

        // Underflow mid-line.
        start = blk[0].lines_done;
        enable = 1'b1;
        n = 0;
        while (!(blk[0].phase == 2 && blk[0].idx >= 20) && n < 400) begin cyc(1); n++; end
        enable = 1'b0;
        stall = 1'b1;
        cyc(3);
        chk(0, "uf_pld_valid", blk[0].pld_valid, 0);
        chk(0, "uf_err_set", blk[0].underflow_err, 1);
        stall = 1'b0;
        cyc(2);
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
        chk(0, "uf_err_cleared", blk[0].underflow_err, 0);
        wait_line0(start + 1, 400, "underflow_line");
        chk(0, "uf_acks", blk[0].last_ack_cnt, 160);

        // Reset at word 50 abandons the line.
        enable = 1'b1;
        n = 0;
        while (!(blk[0].phase == 2 && blk[0].idx >= 50) && n < 600) begin cyc(1); n++; end
        rst_n = 1'b0;
        #1;
        chk(0, "rstm_hdr_valid", blk[0].hdr_valid, 0);
        chk(0, "rstm_pld_valid", blk[0].pld_valid, 0);
        chk(0, "rstm_pld_last", blk[0].pld_last, 0);
        chk(0, "rstm_ack", blk[0].ack, 0);
        chk(0, "rstm_busy", blk[0].busy, 0);
        chk(0, "rstm_crc_valid", blk[0].crc_valid, 0);
        chk(0, "rstm_hdr_data", blk[0].hdr_data, 0);
        chk(0, "rstm_pld_strb", blk[0].pld_strb, 0);
        chk(0, "rstm_crc_data", blk[0].crc_data, 0);
        cyc(3);
        rst_n = 1'b1;
        start = blk[0].lines_done;
        wait_hdr0(50, "hdr_after_reset");
        enable = 1'b0;
        wait_line0(start + 1, 400, "line_after_reset");
        chk(0, "rst_line_acks", blk[0].last_ack_cnt, 160);
        chk(0, "rst_line_cycles", blk[0].last_pld_cyc, 160);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            hdr_ready = ($urandom_range(0, 1) != 0);
            pld_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 9) == 0);
            err_clear = ($urandom_range(0, 30) == 0);
            lr_en     = ($urandom_range(0, 7) != 0);
            cyc(1);
        end
        enable = 1'b0; hdr_ready = 1'b1; pld_ready = 1'b1;
        stall = 1'b0; err_clear = 1'b0; lr_en = 1'b1;
        n = 0;
        while ((blk[0].busy || blk[1].busy || blk[2].busy) && n < 600) begin cyc(1); n++; end
        chk(0, "drain_busy0", blk[0].busy, 0);
        chk(1, "drain_busy1", blk[1].busy, 0);
        chk(2, "drain_busy2", blk[2].busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
